// File: rtl/adder_seq_pkg.sv
// Shared types and default constants for the adder_b host-side sequencer.
package adder_seq_pkg;

    localparam int unsigned DefWidth   = 16;
    localparam int unsigned DefSettle  = 2;
    localparam int unsigned DefTimeout = 64;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitDone,
        StSettle,
        StDrain,
        StResp
    } seq_state_t;

endpackage

// File: rtl/adder_b_sequencer.sv
// Host-side initiator for the Bennett-clocked adder_b: holds operands for a full forward/reverse
// sweep, captures sum/cout after the settle window and returns them on a valid/ready port.
module adder_b_sequencer
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned SETTLE  = DefSettle,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    input  logic             req_cin_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic             op_cin_o,
    input  logic [WIDTH-1:0] add_out_i,
    input  logic             add_cout_i,
    input  logic             add_done_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_sum_o,
    output logic             rsp_cout_o,
    output logic             rsp_err_o
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] SetLast = CntW'((SETTLE > 0) ? SETTLE - 1 : 0);

    seq_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic             live_q;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             err_q, err_d;
    logic             capture;
    logic             abort;

    // Saturating so a stuck adder never wraps the timeout back to zero.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    // live_q keeps req_ready low until the first clock after reset release.
    assign req_ready_o = live_q && (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign op_cin_o    = op_cin_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_cout_o  = cout_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_cin_d = op_cin_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        err_d    = err_q;
        capture  = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The only place operands may change; a mid-sweep change breaks reversibility.
                if (req_valid_i && req_ready_o) begin
                    op_a_d   = req_a_i;
                    op_b_d   = req_b_i;
                    op_cin_d = req_cin_i;
                    sum_d    = '0;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StArm;
                end
            end
            StArm: begin
                // A done flag left over from a previous sweep must clear first.
                if (!add_done_i) begin
                    cnt_d   = cnt_inc;
                    state_d = StWaitDone;
                end else if (cnt_q >= CntLast) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitDone: begin
                if (add_done_i) begin
                    cnt_d = '0;
                    if (SETTLE == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_d = StSettle;
                    end
                end else if (cnt_q >= CntLast) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StSettle: begin
                // An early fall of done still leaves the result valid on this edge.
                if (!add_done_i || (cnt_q >= SetLast)) begin
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDrain: begin
                if (!add_done_i) begin
                    state_d = StResp;
                end else if (cnt_q >= CntLast) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (capture) begin
            sum_d   = add_out_i;
            cout_d  = add_cout_i;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = StDrain;
        end
        if (abort) begin
            sum_d   = '0;
            cout_d  = 1'b0;
            err_d   = 1'b1;
            state_d = StResp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            live_q   <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            live_q   <= 1'b1;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_cin_q <= op_cin_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_adder_b_sequencer.sv
// Bench for adder_b_sequencer with a free-running Bennett-sweep stand-in for adder_b.
module tb_adder_b_sequencer;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int Width   = 16;
    localparam int Timeout = 64;
    localparam int Fwd     = 6;
    localparam int Hold    = 4;
    localparam int Period  = 16;
    localparam int Budget  = 300;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [Width-1:0] req_a = '0;
    logic [Width-1:0] req_b = '0;
    logic             req_cin = 1'b0;
    logic [Width-1:0] op_a, op_b;
    logic             op_cin;
    logic [Width-1:0] add_out;
    logic             add_cout;
    logic             add_done;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [Width-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_mode = 0;  // 0 normal sweep, 1 done stuck low, 2 done stuck high

    always #5 clk = ~clk;

    adder_b_sequencer #(
        .WIDTH  (Width),
        .SETTLE (2),
        .TIMEOUT(Timeout)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i    (req_a),
        .req_b_i    (req_b),
        .req_cin_i  (req_cin),
        .op_a_o     (op_a),
        .op_b_o     (op_b),
        .op_cin_o   (op_cin),
        .add_out_i  (add_out),
        .add_cout_i (add_cout),
        .add_done_i (add_done),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_sum_o  (rsp_sum),
        .rsp_cout_o (rsp_cout),
        .rsp_err_o  (rsp_err)
    );

    // adder_b stand-in: forward sweep, done high for Hold cycles, reverse sweep; garbage when low.
    logic        adder_reset;
    int          phase;
    logic        done_nat;
    logic [16:0] adder_full;
    assign adder_reset = ~rst_n;
    always_ff @(posedge clk or posedge adder_reset) begin
        if (adder_reset) phase <= 0;
        else             phase <= (phase == Period - 1) ? 0 : phase + 1;
    end
    assign done_nat   = (phase >= Fwd) && (phase < Fwd + Hold);
    assign adder_full = {1'b0, op_a} + {1'b0, op_b} + {16'd0, op_cin};
    assign add_out    = done_nat ? adder_full[15:0] : 16'hDEAD;
    assign add_cout   = done_nat ? adder_full[16] : 1'b1;
    assign add_done   = (done_mode == 1) ? 1'b0 : (done_mode == 2) ? 1'b1 : done_nat;

    // Reference: plain integer addition, result {cout, sum}.
    function automatic logic [16:0] ref_add(input int a, input int b, input int cin);
        int total;
        total = a + b + cin;
        return {total >= 65536, 16'(total % 65536)};
    endfunction

    task automatic send_req(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            output logic ok);
        req_a = a;
        req_b = b;
        req_cin = cin;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic consume, output int cycles, output logic ok,
                            output logic [15:0] sum, output logic cout, output logic err);
        cycles = 0;
        ok = 1'b0;
        sum = '0;
        cout = 1'b0;
        err = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        sum = rsp_sum;
        cout = rsp_cout;
        err = rsp_err;
        if (ok && consume) begin
            rsp_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, op_a, op_b, op_cin, rsp_sum, rsp_cout, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b opa=%h opb=%h sum=%h err=%b required all 0",
                     req_ready, rsp_valid, op_a, op_b, rsp_sum, rsp_err);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_clk: got %b required 0", req_ready);
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_clk: got %b required 1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic ok, cout, err;
        logic [15:0] sum;
        logic [16:0] exp;
        int cyc;
        exp = ref_add(32'h1234, 32'h0FFF, 1);
        send_req(16'h1234, 16'h0FFF, 1'b1, ok);
        wait_rsp(1'b1, cyc, ok, sum, cout, err);
        n_tests++;
        if (!ok || sum !== exp[15:0] || cout !== exp[16] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_add: got ok=%b sum=%h cout=%b err=%b required sum=%h cout=%b err=0",
                     ok, sum, cout, err, exp[15:0], exp[16]);
        end
        n_tests++;
        if (cyc < 5) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles required >= 5", cyc);
        end
    endtask

    task automatic test_op_hold();
        logic ok, held;
        logic [16:0] exp;
        exp = ref_add(32'hFFFF, 32'h0001, 0);
        send_req(16'hFFFF, 16'h0001, 1'b0, ok);
        held = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < Budget; i++) begin
            if (op_a !== 16'hFFFF || op_b !== 16'h0001 || op_cin !== 1'b0) held = 1'b0;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL op_hold: got operands changed before RESP required stable FFFF/0001/0");
        end
        n_tests++;
        if (!ok || rsp_sum !== exp[15:0] || rsp_cout !== exp[16] || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_wrap: got ok=%b sum=%h cout=%b required sum=%h cout=%b",
                     ok, rsp_sum, rsp_cout, exp[15:0], exp[16]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic ok, cout, err, stable, blocked;
        logic [15:0] sum, a, b;
        logic [16:0] exp;
        int cyc;
        a = 16'($urandom);
        b = 16'($urandom);
        exp = ref_add(int'(a), int'(b), 0);
        rsp_ready = 1'b0;
        send_req(a, b, 1'b0, ok);
        wait_rsp(1'b0, cyc, ok, sum, cout, err);
        n_tests++;
        if (!ok || sum !== exp[15:0] || cout !== exp[16]) begin
            n_fail++;
            $display("FAIL bp_result: got ok=%b sum=%h cout=%b required sum=%h cout=%b",
                     ok, sum, cout, exp[15:0], exp[16]);
        end
        req_a = 16'h0001;
        req_b = 16'h0001;
        req_cin = 1'b0;
        req_valid = 1'b1;
        stable = 1'b1;
        blocked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== sum || rsp_cout !== cout || rsp_err !== err)
                stable = 1'b0;
            if (req_ready !== 1'b0) blocked = 1'b0;
        end
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_stable: got response changed under backpressure required held %h", sum);
        end
        n_tests++;
        if (!blocked) begin
            n_fail++;
            $display("FAIL bp_req_ready: got req_ready=1 while response pending required 0");
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got rsp_valid=%b after handshake required 0", rsp_valid);
        end
        exp = ref_add(1, 1, 0);
        send_req(16'h0001, 16'h0001, 1'b0, ok);
        wait_rsp(1'b1, cyc, ok, sum, cout, err);
        n_tests++;
        if (!ok || sum !== exp[15:0] || cout !== exp[16] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second: got ok=%b sum=%h required %h", ok, sum, exp[15:0]);
        end
    endtask

    task automatic test_timeout(input int mode);
        logic ok, cout, err;
        logic [15:0] sum;
        int cyc;
        done_mode = mode;
        send_req(16'($urandom), 16'($urandom), 1'($urandom), ok);
        wait_rsp(1'b1, cyc, ok, sum, cout, err);
        done_mode = 0;
        n_tests++;
        if (!ok || err !== 1'b1 || sum !== 16'h0 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_mode%0d: got ok=%b err=%b sum=%h cout=%b required err=1 sum=0 cout=0",
                     mode, ok, err, sum, cout);
        end
        n_tests++;
        if (cyc != Timeout) begin
            n_fail++;
            $display("FAIL timeout_cycles_mode%0d: got %0d required %0d", mode, cyc, Timeout);
        end
    endtask

    task automatic test_reset_mid();
        logic ok, cout, err;
        logic [15:0] sum, a, b;
        logic [16:0] exp;
        int cyc;
        done_mode = 1;
        send_req(16'hA5A5, 16'h5A5A, 1'b1, ok);
        repeat (5) @(negedge clk);
        n_tests++;
        if (op_a !== 16'hA5A5 || op_b !== 16'h5A5A || op_cin !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ops_before_reset: got %h/%h/%b required A5A5/5A5A/1", op_a, op_b, op_cin);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (op_a !== '0 || op_b !== '0 || op_cin !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_abort: got opa=%h opb=%h cin=%b vld=%b rdy=%b required all 0",
                     op_a, op_b, op_cin, rsp_valid, req_ready);
        end
        @(negedge clk);
        done_mode = 0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got rdy=%b vld=%b required rdy=1 vld=0", req_ready, rsp_valid);
        end
        a = 16'($urandom);
        b = 16'($urandom);
        exp = ref_add(int'(a), int'(b), 1);
        send_req(a, b, 1'b1, ok);
        wait_rsp(1'b1, cyc, ok, sum, cout, err);
        n_tests++;
        if (!ok || sum !== exp[15:0] || cout !== exp[16] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_new_req: got ok=%b sum=%h cout=%b required sum=%h cout=%b",
                     ok, sum, cout, exp[15:0], exp[16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] expq[$];
        rsp_ready = 1'b1;
        fork
            begin
                logic ok;
                logic [15:0] a, b;
                logic cin;
                for (int i = 0; i < 8; i++) begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    cin = 1'($urandom);
                    if (i == 0) begin
                        a = 16'hFFFF;
                        b = 16'hFFFF;
                        cin = 1'b1;
                    end
                    expq.push_back(ref_add(int'(a), int'(b), int'(cin)));
                    send_req(a, b, cin, ok);
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL b2b_accept_%0d: got no accept required accept", i);
                    end
                end
            end
            begin
                logic ok, cout, err;
                logic [15:0] sum;
                logic [16:0] exp;
                int cyc;
                for (int i = 0; i < 8; i++) begin
                    wait_rsp(1'b1, cyc, ok, sum, cout, err);
                    exp = (expq.size() > 0) ? expq.pop_front() : 17'h1_FFFF;
                    n_tests++;
                    if (!ok || sum !== exp[15:0] || cout !== exp[16] || err !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_rsp_%0d: got ok=%b sum=%h cout=%b err=%b required sum=%h cout=%b",
                                 i, ok, sum, cout, err, exp[15:0], exp[16]);
                    end
                end
            end
        join
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_leftover: got %0d pending required 0", expq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_op_hold();
        test_backpressure();
        test_timeout(1);
        test_timeout(2);
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
